// File: rtl/ram_array_pkg.sv
// Shared encodings for the 1-bit RAM cell bank controller.
// Holds command opcodes, FSM states and the opcode legality helper.
package ram_array_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_WVERIFY = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    function automatic logic op_legal(input op_e op);
        return (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/ram_onehot_decode.sv
// Address-to-one-hot strobe decoder; the output is all zero while en is low.
module ram_onehot_decode #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [DEPTH-1:0]  onehot
);

    // One strobe per cell, at most one bit high
    always_comb begin
        onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (en && (addr == ADDR_W'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ram_cell_array_master.sv
// Command/response controller sequencing write and read strobes into a bank
// of 1-bit RAM cells, with a write-then-readback verify operation.
module ram_cell_array_master
    import ram_array_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int READ_WAIT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [DEPTH-1:0]  cell_write_enable,
    output logic              cell_write_data,
    output logic [DEPTH-1:0]  cell_read_enable,
    input  logic [DEPTH-1:0]  cell_read_data
);

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LAST_CNT = 4'(READ_WAIT - 1);

    state_e              state_r;
    state_e              state_nxt_s;
    op_e                 op_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                wdata_r;
    logic [3:0]          wait_cnt_r;
    logic                rsp_rdata_r;
    logic                rsp_err_r;
    logic                accept_s;
    logic                read_last_s;
    logic                cmd_ok_s;
    logic                rd_bit_s;
    logic [DEPTH-1:0]    wr_en_s;
    logic [DEPTH-1:0]    rd_en_s;

    assign cmd_ok_s = op_legal(op_e'(cmd_op)) && ({1'b0, cmd_addr} < DEPTH_L);
    // Strobes come only from registered state and latched fields
    assign rd_bit_s = |(cell_read_data & rd_en_s);

    ram_onehot_decode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_decode (
        .addr   (addr_r),
        .en     (state_r == ST_WRITE),
        .onehot (wr_en_s)
    );

    ram_onehot_decode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_decode (
        .addr   (addr_r),
        .en     (state_r == ST_READ),
        .onehot (rd_en_s)
    );

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        read_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    if (!cmd_ok_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (op_e'(cmd_op) == OP_READ) begin
                        state_nxt_s = ST_READ;
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (op_r == OP_WVERIFY) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_READ: begin
                if (wait_cnt_r == LAST_CNT) begin
                    read_last_s = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, latched command fields, read wait counter and response data
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_READ;
            addr_r      <= '0;
            wdata_r     <= 1'b0;
            wait_cnt_r  <= 4'd0;
            rsp_rdata_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r        <= op_e'(cmd_op);
                addr_r      <= cmd_addr;
                wdata_r     <= cmd_wdata;
                rsp_rdata_r <= 1'b0;
                rsp_err_r   <= !cmd_ok_s;
            end else if (read_last_s) begin
                rsp_rdata_r <= rd_bit_s;
                rsp_err_r   <= (op_r == OP_WVERIFY) && (rd_bit_s != wdata_r);
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_rdata_r <= 1'b0;
                rsp_err_r   <= 1'b0;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
                rsp_err_r   <= rsp_err_r;
            end
            if ((state_r == ST_READ) && !read_last_s) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end
        end
    end

    assign cmd_ready         = (state_r == ST_IDLE);
    assign busy              = (state_r != ST_IDLE);
    assign rsp_valid         = (state_r == ST_RESP);
    assign rsp_rdata         = rsp_rdata_r;
    assign rsp_err           = rsp_err_r;
    assign cell_write_enable = wr_en_s;
    assign cell_read_enable  = rd_en_s;
    assign cell_write_data   = (state_r == ST_WRITE) & wdata_r;

endmodule
